// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
//   Single-clock FIFO with a power-of-2 depth. The read side runs either as
//   first-word-fall-through (P_FWFT=1) or as a standard request/response read
//   (P_FWFT=0). The FIFO also provides an occupancy count, programmable
//   almost-full/almost-empty flags and a synchronous flush. The storage array
//   is written for block-RAM inference with a synchronous read port.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of all contents (highest priority)
//   wr_data      write word
//   wr_vld       write request
//   wr_rdy       space available (fill_cnt < P_DEPTH)
//   rd_data      read word
//   rd_vld       FWFT: head word valid; standard: one-cycle read response
//   rd_rdy       FWFT: consumer accepts head word; standard: read request
//   empty        no word available to read
//   fill_cnt     words accepted and not yet consumed
//   almost_full  fill_cnt >= P_AF_LEVEL
//   almost_empty fill_cnt <= P_AE_LEVEL
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter int P_DEPTH    = 1024,
  parameter int P_WIDTH    = 8,
  parameter int P_FWFT     = 1,
  parameter int P_AF_LEVEL = P_DEPTH - 2,
  parameter int P_AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [P_WIDTH-1:0]         wr_data,
  input  logic                       wr_vld,
  output logic                       wr_rdy,
  output logic [P_WIDTH-1:0]         rd_data,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic                       empty,
  output logic [$clog2(P_DEPTH):0]   fill_cnt,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(P_DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(P_AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(P_AE_LEVEL);

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               wr_en;    // word written into memory this edge
  logic               rd_en;    // memory read issued this edge (rd_ptr advances)
  logic               rd_take;  // word leaves the FIFO this edge (pop / accepted read)

  // Flow control and flags come from registered fill_cnt only.
  assign wr_rdy       = (fill_cnt < DEPTH_C);
  assign wr_en        = wr_vld & wr_rdy & ~flush;
  assign almost_full  = (fill_cnt >= AF_C);
  assign almost_empty = (fill_cnt <= AE_C);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_take})
        2'b10:   fill_cnt <= fill_cnt + 1'b1;
        2'b01:   fill_cnt <= fill_cnt - 1'b1;
        default: fill_cnt <= fill_cnt;
      endcase
    end
  end

  if (P_FWFT != 0) begin : g_fwft
    // Two-stage read pipeline: ram_q is the synchronous RAM output (prefetch
    // slot, pf_vld), rd_data is the head register (rd_vld). The prefetch slot
    // is refilled whenever it empties in the same edge, so back-to-back pops
    // stream at one word per cycle. fill_cnt counts words in both stages.
    logic [P_WIDTH-1:0] ram_q;
    logic               pf_vld;
    logic               pf_move;

    assign rd_take = rd_vld & rd_rdy & ~flush;
    assign pf_move = pf_vld & (~rd_vld | rd_take);
    assign rd_en   = (wr_ptr != rd_ptr) & (~pf_vld | pf_move) & ~flush;
    assign empty   = ~rd_vld;

    always_ff @(posedge clk) begin
      if (rd_en) begin
        ram_q <= mem[rd_ptr[AW-1:0]];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pf_vld  <= 1'b0;
        rd_vld  <= 1'b0;
        rd_data <= '0;
      end else if (flush) begin
        pf_vld <= 1'b0;
        rd_vld <= 1'b0;
      end else begin
        if (rd_en) begin
          pf_vld <= 1'b1;
        end else if (pf_move) begin
          pf_vld <= 1'b0;
        end
        if (pf_move) begin
          rd_data <= ram_q;
          rd_vld  <= 1'b1;
        end else if (rd_take) begin
          rd_vld <= 1'b0;
        end
      end
    end
  end else begin : g_std
    assign empty   = (fill_cnt == '0);
    assign rd_en   = rd_rdy & ~empty & ~flush;
    assign rd_take = rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_vld  <= 1'b0;
        rd_data <= '0;
      end else begin
        rd_vld <= rd_en;
        if (rd_en) begin
          rd_data <= mem[rd_ptr[AW-1:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_fwft
//   Drives one FWFT and one standard-mode instance (depth 8) with identical
//   stimulus. A queue-based reference model decides acceptance, occupancy and
//   head visibility; read data is checked against scoreboard queues by a
//   separate monitor.
// ---------------------------------------------------------------------------
module tb_sync_fifo_fwft;

  localparam int DEPTH = 8;
  localparam int W     = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         wr_vld;
  logic         rd_rdy;
  logic [W-1:0] wr_data;

  logic         fw_wr_rdy, fw_rd_vld, fw_empty, fw_af, fw_ae;
  logic [W-1:0] fw_rd_data;
  logic [3:0]   fw_fill;
  logic         st_wr_rdy, st_rd_vld, st_empty, st_af, st_ae;
  logic [W-1:0] st_rd_data;
  logic [3:0]   st_fill;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.P_DEPTH(DEPTH), .P_WIDTH(W), .P_FWFT(1), .P_AF_LEVEL(AF), .P_AE_LEVEL(AE)) u_fw (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_data(wr_data), .wr_vld(wr_vld), .wr_rdy(fw_wr_rdy),
    .rd_data(fw_rd_data), .rd_vld(fw_rd_vld), .rd_rdy(rd_rdy),
    .empty(fw_empty), .fill_cnt(fw_fill),
    .almost_full(fw_af), .almost_empty(fw_ae)
  );

  sync_fifo_fwft #(.P_DEPTH(DEPTH), .P_WIDTH(W), .P_FWFT(0), .P_AF_LEVEL(AF), .P_AE_LEVEL(AE)) u_st (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_data(wr_data), .wr_vld(wr_vld), .wr_rdy(st_wr_rdy),
    .rd_data(st_rd_data), .rd_vld(st_rd_vld), .rd_rdy(rd_rdy),
    .empty(st_empty), .fill_cnt(st_fill),
    .almost_full(st_af), .almost_empty(st_ae)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model state (state after the most recent edge).
  int           fq[$];      // FWFT: edge index at which each held word was written
  logic [W-1:0] sb_fw[$];   // FWFT: expected words in order
  logic [W-1:0] sq[$];      // standard: held words
  logic [W-1:0] sb_st[$];   // standard: response expected in the next cycle
  bit           fw_vis = 1'b0;
  int           edge_no = 0;

  // Model: runs after the monitor, with the inputs for the coming edge stable.
  always begin : model
    bit fw_pop, fw_wr, st_rd, st_wr;
    @(negedge clk);
    #2;
    if (!rst_n || flush) begin
      fq.delete();
      sb_fw.delete();
      sq.delete();
      sb_st.delete();
      fw_vis = 1'b0;
    end else begin
      fw_pop = fw_vis && rd_rdy;
      fw_wr  = wr_vld && (fq.size() < DEPTH);
      if (fw_pop) void'(fq.pop_front());
      if (fw_wr) begin
        fq.push_back(edge_no);
        sb_fw.push_back(wr_data);
      end
      st_rd = rd_rdy && (sq.size() > 0);
      st_wr = wr_vld && (sq.size() < DEPTH);
      if (st_rd) sb_st.push_back(sq.pop_front());
      if (st_wr) sq.push_back(wr_data);
      // A word is at the head two edges after its write, provided all
      // earlier words have been popped.
      fw_vis = (fq.size() > 0) && (edge_no - fq[0] >= 2);
    end
    edge_no++;
  end

  // Monitor: compares DUT outputs mid-cycle against the model.
  always @(negedge clk) begin : monitor
    logic [W-1:0] exp_d;
    if (rst_n) begin
      chk("fw_fill",   int'(fw_fill),   fq.size());
      chk("fw_wr_rdy", int'(fw_wr_rdy), int'(fq.size() < DEPTH));
      chk("fw_af",     int'(fw_af),     int'(fq.size() >= AF));
      chk("fw_ae",     int'(fw_ae),     int'(fq.size() <= AE));
      chk("fw_rd_vld", int'(fw_rd_vld), int'(fw_vis));
      chk("fw_empty",  int'(fw_empty),  int'(!fw_vis));
      if (fw_rd_vld) begin
        if (sb_fw.size() == 0) begin
          chk("fw_rd_unexpected", int'(fw_rd_vld), 0);
        end else begin
          chk("fw_rd_data", int'(fw_rd_data), int'(sb_fw[0]));
          if (rd_rdy && !flush) void'(sb_fw.pop_front());
        end
      end
      chk("st_fill",   int'(st_fill),   sq.size());
      chk("st_wr_rdy", int'(st_wr_rdy), int'(sq.size() < DEPTH));
      chk("st_af",     int'(st_af),     int'(sq.size() >= AF));
      chk("st_ae",     int'(st_ae),     int'(sq.size() <= AE));
      chk("st_empty",  int'(st_empty),  int'(sq.size() == 0));
      chk("st_rd_vld", int'(st_rd_vld), int'(sb_st.size() > 0));
      if (sb_st.size() > 0) begin
        exp_d = sb_st.pop_front();
        if (st_rd_vld) chk("st_rd_data", int'(st_rd_data), int'(exp_d));
      end
    end
  end

  task automatic drive(input bit wv, input logic [W-1:0] wd, input bit rr, input bit fl);
    wr_vld  = wv;
    wr_data = wd;
    rd_rdy  = rr;
    flush   = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_fw_fill"},  int'(fw_fill), 0);
    chk({tag, "_fw_vld"},   int'(fw_rd_vld), 0);
    chk({tag, "_fw_data"},  int'(fw_rd_data), 0);
    chk({tag, "_fw_wrdy"},  int'(fw_wr_rdy), 1);
    chk({tag, "_fw_empty"}, int'(fw_empty), 1);
    chk({tag, "_fw_ae"},    int'(fw_ae), 1);
    chk({tag, "_fw_af"},    int'(fw_af), 0);
    chk({tag, "_st_fill"},  int'(st_fill), 0);
    chk({tag, "_st_vld"},   int'(st_rd_vld), 0);
    chk({tag, "_st_data"},  int'(st_rd_data), 0);
    chk({tag, "_st_wrdy"},  int'(st_wr_rdy), 1);
    chk({tag, "_st_empty"}, int'(st_empty), 1);
  endtask

  // Asynchronous reset pulse taken between edges; outputs must clear at once.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int pw, pr;
    rst_n   = 1'b0;
    flush   = 1'b0;
    wr_vld  = 1'b0;
    rd_rdy  = 1'b0;
    wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("init_rst");
    rst_n = 1'b1;
    drive(0, 8'h00, 0, 0);

    // Fill to full (9th write refused), then drain.
    for (int i = 1; i <= 9; i++) drive(1, 8'(i), 0, 0);
    repeat (2) drive(0, 8'h00, 0, 0);
    repeat (12) drive(0, 8'h00, 1, 0);

    // Single word into empty FIFO, held at the head, then popped.
    drive(1, 8'hA5, 0, 0);
    repeat (6) drive(0, 8'h00, 0, 0);
    repeat (2) drive(0, 8'h00, 1, 0);

    // Three words drained by a continuous read request.
    drive(1, 8'h10, 0, 0);
    drive(1, 8'h11, 0, 0);
    drive(1, 8'h12, 0, 0);
    repeat (6) drive(0, 8'h00, 1, 0);

    // Steady streaming at occupancy 4; pointers wrap several times.
    for (int i = 0; i < 4; i++) drive(1, 8'(8'h20 + i), 0, 0);
    repeat (2) drive(0, 8'h00, 0, 0);
    for (int i = 0; i < 40; i++) drive(1, 8'(8'h30 + i), 1, 0);
    repeat (8) drive(0, 8'h00, 1, 0);

    // Full with simultaneous write and pop, then the write retried.
    for (int i = 0; i < 8; i++) drive(1, 8'(8'h80 + i), 0, 0);
    repeat (2) drive(0, 8'h00, 0, 0);
    drive(1, 8'h55, 1, 0);
    drive(1, 8'h55, 0, 0);
    repeat (12) drive(0, 8'h00, 1, 0);

    // Flush with 5 words held while a write and read are requested.
    for (int i = 0; i < 5; i++) drive(1, 8'(8'hC0 + i), 0, 0);
    repeat (2) drive(0, 8'h00, 0, 0);
    drive(1, 8'hEE, 1, 1);
    repeat (3) drive(0, 8'h00, 0, 0);

    // Reset mid-stream.
    for (int i = 0; i < 6; i++) drive(1, 8'(8'hD0 + i), i[0], 0);
    reset_pulse();
    repeat (2) drive(0, 8'h00, 0, 0);

    // Randomized traffic with shifting bias, occasional flush and reset.
    pw = 50;
    pr = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        pw = int'($urandom_range(10, 95));
        pr = int'($urandom_range(10, 95));
      end
      if ($urandom_range(0, 599) == 0) begin
        reset_pulse();
      end else begin
        drive(($urandom_range(0, 99) < pw), 8'($urandom), ($urandom_range(0, 99) < pr),
              ($urandom_range(0, 149) == 0));
      end
    end
    repeat (12) drive(0, 8'h00, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Single-clock, parametrised successor to the dual-clock FIFO.
- Same valid/ready write and read handshakes, and the same power-of-2 depth with a pointer carrying one extra wrap bit.
- Adds:
  - selectable first-word-fall-through (FWFT) or standard read mode;
  - occupancy count;
  - programmable almost-full and almost-empty flags;
  - synchronous flush.
- Used wherever producer and consumer share a clock. Memory is written so the tools infer block RAM with a synchronous read.

Parameters:
- P_DEPTH, 1024, total capacity in words; must be a power of 2, ≥4.
- P_WIDTH, 8, data word width.
- P_FWFT, 1, 1 = FWFT read mode, 0 = standard read mode.
- P_AF_LEVEL, P_DEPTH-2, almost_full asserts when fill_cnt ≥ this value; range 1..P_DEPTH.
- P_AE_LEVEL, 1, almost_empty asserts when fill_cnt ≤ this value; range 0..P_DEPTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all contents.
- wr_data  in  P_WIDTH  write word.
- wr_vld  in  1  write request.
- wr_rdy  out  1  space available (~full).
- rd_data  out  P_WIDTH  read word.
- rd_vld  out  1  rd_data valid (meaning depends on mode).
- rd_rdy  in  1  FWFT: consumer accepts head word; standard: read request.
- empty  out  1  no word available to read.
- fill_cnt  out  clog2(P_DEPTH)+1  words accepted and not yet consumed.
- almost_full  out  1  fill_cnt ≥ P_AF_LEVEL.
- almost_empty  out  1  fill_cnt ≤ P_AE_LEVEL.

Behaviour:
- Reset (async assert; deassert sampled on clk):
  - pointers = 0, fill_cnt = 0, rd_data register = 0, rd_vld = 0;
  - wr_rdy = 1, empty = 1, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
- Pointers:
  - binary, clog2(P_DEPTH)+1 bits; wrap naturally.
  - Memory address = pointer without its MSB.
- Write: accepted on a rising edge when wr_vld & wr_rdy. Data is stored and the write pointer increments.
- wr_rdy = (fill_cnt < P_DEPTH). It is derived from registered state only, so a read in the same cycle never frees space for that cycle's write.
- FWFT mode (P_FWFT=1):
  - An output register holds the head word; rd_vld = head valid; empty = ~rd_vld.
  - A pop occurs on rd_vld & rd_rdy.
  - The output register refills from memory using a prefetch; back-to-back pops sustain 1 word/cycle when ≥2 words are held.
  - Latency: a word accepted into an empty FIFO at edge N gives rd_vld=1 after edge N+2.
  - rd_data is stable while rd_vld & ~rd_rdy.
  - Any word in the output register or prefetch path counts in fill_cnt.
- Standard mode (P_FWFT=0):
  - empty = (fill_cnt == 0).
  - A read is accepted at an edge when rd_rdy & ~empty.
  - rd_data is updated and rd_vld=1 for exactly the following cycle; rd_vld=0 on all other cycles.
  - Continuous rd_rdy drains 1 word/cycle.
  - rd_rdy while empty is ignored: no pointer change, rd_vld=0.
- fill_cnt: +1 on an accepted write, −1 on an accepted read/pop, unchanged when both occur. Never exceeds P_DEPTH and never wraps below 0.
- Flags:
  - almost_full and almost_empty decode combinationally from registered fill_cnt, so they update in the cycle after the causing edge.
  - Both may be asserted simultaneously if the levels overlap.
- Simultaneous write and read while empty:
  - FWFT: no read is possible (rd_vld=0); the write is accepted.
  - Standard: the read is ignored; the write is accepted.
- Simultaneous write and read while full: the write is refused (wr_rdy=0); the read proceeds; wr_rdy=1 next cycle.
- Flush:
  - Highest priority in its cycle; writes and reads in that cycle are discarded.
  - Next cycle, outputs take their reset values (rd_data holds its previous value).
- Reset asserted mid-operation: immediate return to reset values; all stored words are lost.

Test Plan:
- P_DEPTH=8, FWFT: write 0x01..0x08 with rd_rdy=0 → wr_rdy=0 after the 8th write, fill_cnt=8, almost_full=1 from fill_cnt=6; a 9th wr_vld is not accepted.
- FWFT, empty: single write 0xA5 at edge N → rd_vld=1 and rd_data=0xA5 after edge N+2; hold rd_rdy=0 for 5 cycles → data stable; pop → empty=1, fill_cnt=0.
- Standard mode: fill 0x10,0x11,0x12; hold rd_rdy=1 → rd_vld pulses 3 consecutive cycles carrying 0x10,0x11,0x12, then rd_vld=0; extra rd_rdy while empty has no effect.
- Continuous wr_vld=rd_vld=1 for 40 cycles at fill_cnt=4 → fill_cnt stays 4; output order matches input order; pointers wrap ≥4 times.
- Full with simultaneous write and pop → write refused that cycle, fill_cnt=7, wr_rdy=1 next cycle; 0x55 then accepted.
- flush=1 with 5 words held and wr_vld=1 → next cycle fill_cnt=0, empty=1, rd_vld=0; rst_n pulsed low mid-stream → immediate reset values.
